// File: rtl/maclaurin_cu_if.sv
// maclaurin_cu_if: request/strobe bundle between the Maclaurin sequencer and its datapath
interface maclaurin_cu_if #(parameter int CW = 4);
  logic          start;
  logic [1:0]    mode;
  logic          abort;
  logic          done;
  logic          err;
  logic          ldX;
  logic          initT;
  logic          initS;
  logic          ldT;
  logic          ldS;
  logic          cntUp;
  logic          selX2;
  logic          selOne;
  logic          addSub;
  logic [CW+1:0] coefAddr;
  modport master(
    output start, mode, abort,
    input  done, err, ldX, initT, initS, ldT, ldS, cntUp, selX2, selOne, addSub, coefAddr
  );
  modport slave(
    input  start, mode, abort,
    output done, err, ldX, initT, initS, ldT, ldS, cntUp, selX2, selOne, addSub, coefAddr
  );
endinterface

// File: rtl/maclaurin_cu.sv
// maclaurin_cu: sequencer that steps a sin/cos/exp Maclaurin series through its datapath
module maclaurin_cu #(
  parameter int NTERMS = 8,
  parameter int CW     = 4
) (
  input logic          clk,
  input logic          rst,
  maclaurin_cu_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ARM, LOADX, INIT, MULT1, MULT2, ADD} state_t;
  localparam logic [CW-1:0] KMAX = CW'(NTERMS - 1);
  state_t        state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [1:0]    mode_r_q, mode_r_d;
  logic          err_q, err_d;
  logic          run;
  // state and job registers, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      mode_r_q <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      mode_r_q <= mode_r_d;
      err_q    <= err_d;
    end
  end
  // next state: abort wins over every busy-state transition, start is only seen in IDLE
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    mode_r_d = mode_r_q;
    err_d    = err_q;
    if (state_q == IDLE) begin
      if (bus.start) begin
        err_d = bus.mode == 2'b11;
        if (bus.mode != 2'b11) begin
          mode_r_d = bus.mode;
          state_d  = ARM;
        end
      end
    end else if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ARM:     state_d = bus.start ? ARM : LOADX;
        LOADX:   state_d = INIT;
        INIT: begin
          k_d     = CW'(1);
          state_d = MULT1;
        end
        MULT1:   state_d = MULT2;
        MULT2:   state_d = ADD;
        ADD: begin
          state_d = (k_q == KMAX) ? IDLE : MULT1;
          k_d     = (k_q == KMAX) ? k_q : k_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // strobes decode the registered state; a pending abort suppresses them all
  always_comb begin
    run         = !bus.abort;
    bus.done    = state_q == IDLE;
    bus.err     = err_q;
    bus.ldX     = run && state_q == LOADX;
    bus.initT   = run && state_q == INIT;
    bus.initS   = run && state_q == INIT;
    bus.selOne  = run && state_q == INIT && mode_r_q != 2'b00;
    bus.ldT     = run && (state_q == MULT1 || state_q == MULT2);
    bus.selX2   = run && state_q == MULT1 && mode_r_q != 2'b10;
    bus.ldS     = run && state_q == ADD;
    bus.cntUp   = run && state_q == ADD;
    bus.addSub  = run && state_q == ADD && mode_r_q != 2'b10 && k_q[0];
    bus.coefAddr = {mode_r_q, k_q};
  end
endmodule

// File: doc/maclaurin_cu.md
MACLAURIN_CU -- requirements
Module: maclaurin_cu

Interface
REQ-001 The block SHALL have parameter NTERMS, default 8, number of series terms including the initial term (legal 2..2^CW).
REQ-002 The block SHALL have parameter CW, default 4, width of the term index counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, request level; a job launches on its high-then-low sequence.
REQ-006 The block SHALL have port mode, input, 2, function select: 00 sin, 01 cos, 10 exp, 11 illegal.
REQ-007 The block SHALL have port abort, input, 1, cancels a job in progress.
REQ-008 The block SHALL have port done, output, 1, high while idle.
REQ-009 The block SHALL have port err, output, 1, registered flag for an illegal mode request.
REQ-010 The block SHALL have ports ldX, initT, initS, ldT, ldS, cntUp, selX2, selOne, addSub, output, 1 each, datapath strobes.
REQ-011 The block SHALL have port coefAddr, output, CW+2, coefficient ROM address {mode_r, k}.

Function
REQ-012 The FSM SHALL have states IDLE, ARM, LOADX, INIT, MULT1, MULT2, ADD; all strobes are Moore outputs decoded from the registered state and default to 0.
REQ-013 IDLE: done=1; start=1 with mode!=11 latches mode into mode_r and goes to ARM; start=1 with mode==11 stays IDLE and sets err.
REQ-014 err SHALL clear on the next start accepted with a legal mode; otherwise it holds.
REQ-015 ARM: stay while start=1; go to LOADX on start=0.
REQ-016 LOADX: ldX=1; next INIT.
REQ-017 INIT: initT=1, initS=1, selOne=1 when mode_r is cos or exp (initial term 1), selOne=0 for sin (initial term x); k loads 1; next MULT1.
REQ-018 MULT1: ldT=1; selX2=1 for sin/cos (multiply by x^2), selX2=0 for exp (multiply by x); next MULT2.
REQ-019 MULT2: ldT=1 (term multiplied by ROM coefficient at coefAddr); next ADD.
REQ-020 ADD: ldS=1, cntUp=1; addSub=1 (subtract) when mode_r is sin/cos and k is odd, else 0; if k==NTERMS-1 next IDLE, else k increments and next MULT1.
REQ-021 coefAddr SHALL equal {mode_r, k} in every state; k SHALL never wrap, its maximum being NTERMS-1.
REQ-022 Latency: with the first LOADX cycle as cycle 1, the last ADD SHALL occur in cycle 2+3*(NTERMS-1) and done SHALL be high in the following cycle (cycle 24 for NTERMS=8).
REQ-023 abort=1 in any state other than IDLE SHALL force IDLE on the next edge with all strobes 0 in the cycle abort is sampled; a partial sum is not written.
REQ-024 abort and start both high in IDLE: abort SHALL be ignored and start handled per REQ-013.
REQ-025 mode changes after IDLE SHALL not affect the running job (mode_r only).
REQ-026 abort has priority over the ADD-to-IDLE or ADD-to-MULT1 transition when both apply in the same cycle.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, k=0, mode_r=00, err=0, regardless of clk.
REQ-028 During and right after reset, done=1 and all other outputs SHALL be 0, with coefAddr=0.
REQ-029 A reset asserted mid-job SHALL abandon the job with no further ldS strobes.

Verification
REQ-030 Sin, NTERMS=8: start high 2 cycles then low -> one LOADX, one INIT with selOne=0, 7 ADD pulses with addSub 1,0,1,0,1,0,1 and k=1..7, done high at cycle 24.
REQ-031 Cos and exp jobs: INIT has selOne=1; exp gives selX2=0 and addSub=0 on all 7 ADDs; coefAddr upper bits are 01 and 10 respectively.
REQ-032 mode=11 with start pulse -> stays IDLE, err=1; next start with mode=00 -> err=0, job runs.
REQ-033 abort asserted in MULT2 at k=3 -> IDLE next cycle, no ldS in that cycle, done=1.
REQ-034 rst pulled low during ADD at k=5, asynchronous to clk -> outputs go to reset values immediately; a fresh job then completes normally.
REQ-035 Start held high for 10 cycles -> block remains in ARM with no strobes; LOADX follows exactly one cycle after start drops.
